// File: rtl/accel_pkg.sv
`default_nettype none
// ============================================================================
// accel_pkg
// Shared register map, CTRL/STATUS bit positions, FSM state and decode
// region encodings, plus the byte-lane merge helper used for bus writes.
// Revision: 1.0
// ============================================================================
package accel_pkg;

  // Register offsets from the window base.
  localparam logic [6:0] OFF_CTRL   = 7'h00;
  localparam logic [6:0] OFF_STATUS = 7'h04;
  localparam logic [6:0] OFF_KEY    = 7'h20;
  localparam logic [6:0] OFF_BLK    = 7'h40;
  localparam logic [6:0] OFF_RES    = 7'h60;

  // CTRL bit positions.
  localparam int CTRL_START    = 0;
  localparam int CTRL_IRQ_EN   = 1;
  localparam int CTRL_DONE_CLR = 2;

  // STATUS bit positions.
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;

  // Sequencer states; fixed 2-bit encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  // Which register group a decoded address selects.
  typedef enum logic [2:0] {
    RG_NONE   = 3'd0,
    RG_CTRL   = 3'd1,
    RG_STATUS = 3'd2,
    RG_KEY    = 3'd3,
    RG_BLK    = 3'd4,
    RG_RES    = 3'd5
  } region_e;

  // Replace only the byte lanes whose select bit is set.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/accel_wb_regs_if.sv
`default_nettype none
// ============================================================================
// accel_wb_regs_if
// Wishbone classic slave bus bundle between the host and the register block.
// Revision: 1.0
// ============================================================================
interface accel_wb_regs_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface
`default_nettype wire

// File: rtl/accel_wb_if.sv
`default_nettype none
// ============================================================================
// accel_wb_if
// Single-cycle Wishbone ack generator and register-window address decoder.
// req marks the edge at which a transfer is accepted (and acked next cycle).
// Revision: 1.0
// ============================================================================
module accel_wb_if
  import accel_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          KEY_WORDS = 8,
  parameter int          BLK_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cyc,
  input  logic        stb,
  input  logic [31:0] adr,
  output logic        req,
  output logic        ack,
  output region_e     region,
  output logic [2:0]  idx
);

  localparam logic [3:0] KEY_LIM = 4'(KEY_WORDS);
  localparam logic [3:0] BLK_LIM = 4'(BLK_WORDS);

  logic [31:0] off;

  // A new transfer is taken only while ack is low, so acks never run back to back.
  assign req = cyc & stb & ~ack;
  assign off = adr - BASE_ADDR;
  assign idx = off[4:2];

  // Ack pulses exactly one cycle after the transfer is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ack <= 1'b0;
    else     ack <= req;
  end

  // Word-aligned offsets inside the 128-byte window map to a register group.
  always_comb begin
    region = RG_NONE;
    if (off[31:7] == 25'd0 && off[1:0] == 2'b00) begin
      case (off[6:5])
        OFF_CTRL[6:5]: begin
          if (off[4:2] == OFF_CTRL[4:2])        region = RG_CTRL;
          else if (off[4:2] == OFF_STATUS[4:2]) region = RG_STATUS;
        end
        OFF_KEY[6:5]: if ({1'b0, idx} < KEY_LIM) region = RG_KEY;
        OFF_BLK[6:5]: if ({1'b0, idx} < BLK_LIM) region = RG_BLK;
        default:      if ({1'b0, idx} < BLK_LIM) region = RG_RES;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/accel_wb_regs.sv
`default_nettype none
// ============================================================================
// accel_wb_regs
// Wishbone register front-end for a block crypto core: key/block/result
// registers, a start/wait sequencer, sticky DONE/ERR and a level interrupt.
// Revision: 1.0
// ============================================================================
module accel_wb_regs
  import accel_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          KEY_WORDS = 8,
  parameter int          BLK_WORDS = 4
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  accel_wb_regs_if.slave          wbs,
  output logic [32*KEY_WORDS-1:0] core_key_o,
  output logic [32*BLK_WORDS-1:0] core_blk_o,
  output logic                    core_start_o,
  input  logic                    core_busy_i,
  input  logic                    core_done_i,
  input  logic [32*BLK_WORDS-1:0] core_res_i,
  output logic                    irq_o
);

  logic [31:0] key_q [KEY_WORDS];
  logic [31:0] blk_q [BLK_WORDS];
  logic [31:0] res_q [BLK_WORDS];
  state_e      state_q;
  logic        irq_en_q, done_q, err_q, irq_q;
  logic [31:0] dat_q;
  logic [31:0] rd_data;

  logic        req, ack;
  region_e     region;
  logic [2:0]  idx;
  logic        wr, idle, wr_ctrl, start_req, done_clr, capture, err_set;
  logic        unused_busy;

  // The sequencer tracks the core on its own; the core's busy flag is not needed.
  assign unused_busy = core_busy_i;

  accel_wb_if #(
    .BASE_ADDR (BASE_ADDR),
    .KEY_WORDS (KEY_WORDS),
    .BLK_WORDS (BLK_WORDS)
  ) u_wb_if (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .cyc    (wbs.wbs_cyc_i),
    .stb    (wbs.wbs_stb_i),
    .adr    (wbs.wbs_adr_i),
    .req    (req),
    .ack    (ack),
    .region (region),
    .idx    (idx)
  );

  assign wr        = req & wbs.wbs_we_i;
  assign idle      = (state_q == ST_IDLE);
  assign wr_ctrl   = wr & (region == RG_CTRL) & wbs.wbs_sel_i[0];
  assign start_req = wr_ctrl & wbs.wbs_dat_i[CTRL_START];
  assign done_clr  = wr_ctrl & wbs.wbs_dat_i[CTRL_DONE_CLR];
  assign capture   = (state_q == ST_WAIT) & core_done_i;
  assign err_set   = ~idle & (start_req | (wr & (region == RG_KEY || region == RG_BLK)));

  assign wbs.wbs_ack_o = ack;
  assign wbs.wbs_dat_o = dat_q;
  assign core_start_o  = (state_q == ST_START);
  assign irq_o         = irq_q;

  generate
    for (genvar i = 0; i < KEY_WORDS; i++) begin : g_key
      assign core_key_o[32*i +: 32] = key_q[i];
    end
    for (genvar i = 0; i < BLK_WORDS; i++) begin : g_blk
      assign core_blk_o[32*i +: 32] = blk_q[i];
    end
  endgenerate

  // Key and block registers accept byte-lane writes only while the core is idle.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < KEY_WORDS; i++) key_q[i] <= '0;
      for (int i = 0; i < BLK_WORDS; i++) blk_q[i] <= '0;
    end else if (wr && idle) begin
      for (int i = 0; i < KEY_WORDS; i++) begin
        if (region == RG_KEY && idx == 3'(i))
          key_q[i] <= byte_merge(key_q[i], wbs.wbs_dat_i, wbs.wbs_sel_i);
      end
      for (int i = 0; i < BLK_WORDS; i++) begin
        if (region == RG_BLK && idx == 3'(i))
          blk_q[i] <= byte_merge(blk_q[i], wbs.wbs_dat_i, wbs.wbs_sel_i);
      end
    end
  end

  // Result words are captured only on a done pulse seen while waiting.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < BLK_WORDS; i++) res_q[i] <= '0;
    end else if (capture) begin
      for (int i = 0; i < BLK_WORDS; i++) res_q[i] <= core_res_i[32*i +: 32];
    end
  end

  // Sequencer: IDLE -> START (one-cycle pulse) -> WAIT until core done.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (start_req) state_q <= ST_START;
        ST_START: state_q <= ST_WAIT;
        ST_WAIT:  if (core_done_i) state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  // Control/status flags; a set event wins over a same-cycle clear.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en_q <= wbs.wbs_dat_i[CTRL_IRQ_EN];
      if (capture)       done_q <= 1'b1;
      else if (done_clr) done_q <= 1'b0;
      if (err_set)       err_q <= 1'b1;
      else if (done_clr) err_q <= 1'b0;
      irq_q <= done_q & irq_en_q;
    end
  end

  // Read multiplexer; unmapped and write-only bits read as zero.
  always_comb begin
    rd_data = '0;
    case (region)
      RG_CTRL: rd_data[CTRL_IRQ_EN] = irq_en_q;
      RG_STATUS: begin
        rd_data[STAT_BUSY] = ~idle;
        rd_data[STAT_DONE] = done_q;
        rd_data[STAT_ERR]  = err_q;
      end
      RG_KEY: begin
        for (int i = 0; i < KEY_WORDS; i++) if (idx == 3'(i)) rd_data = key_q[i];
      end
      RG_BLK: begin
        for (int i = 0; i < BLK_WORDS; i++) if (idx == 3'(i)) rd_data = blk_q[i];
      end
      RG_RES: begin
        for (int i = 0; i < BLK_WORDS; i++) if (idx == 3'(i)) rd_data = res_q[i];
      end
      default: rd_data = '0;
    endcase
  end

  // Read data is registered alongside ack so the bus sees it only in the ack cycle.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)                  dat_q <= '0;
    else if (req && !wbs.wbs_we_i) dat_q <= rd_data;
    else                           dat_q <= '0;
  end

endmodule
`default_nettype wire

// File: tb/tb_accel_wb_regs.sv
`default_nettype none
// ============================================================================
// tb_accel_wb_regs
// Directed bench for the accelerator register block.
// Revision: 1.0
// ============================================================================
module tb_accel_wb_regs;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] A_CTRL   = BASE + 32'h00;
  localparam logic [31:0] A_STATUS = BASE + 32'h04;
  localparam logic [31:0] A_KEY0   = BASE + 32'h20;
  localparam logic [31:0] A_BLK0   = BASE + 32'h40;
  localparam logic [31:0] A_RES0   = BASE + 32'h60;

  logic          clk, rst;
  logic [255:0]  core_key;
  logic [127:0]  core_blk;
  logic          core_start, core_busy, core_done, irq;
  logic [127:0]  core_res;

  accel_wb_regs_if bus ();

  accel_wb_regs dut (
    .wb_clk_i     (clk),
    .wb_rst_i     (rst),
    .wbs          (bus),
    .core_key_o   (core_key),
    .core_blk_o   (core_blk),
    .core_start_o (core_start),
    .core_busy_i  (core_busy),
    .core_done_i  (core_done),
    .core_res_i   (core_res),
    .irq_o        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int start_cnt = 0;
  always @(negedge clk) if (core_start === 1'b1) start_cnt++;

  int          passed = 0;
  int          total  = 0;
  int          lat;
  logic        dbl;
  logic [31:0] rdat, dat_after;

  logic [255:0] exp_key;
  logic [127:0] exp_blk;
  localparam logic [127:0] RES_VAL = 128'h01234567_89ABCDEF_FEDCBA98_7654CDEF;

  // One bus transfer; records ack latency, read data, and the following cycle.
  task automatic wb_xfer(input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel,
                         input logic pulse_done);
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
    bus.wbs_adr_i = adr;  bus.wbs_dat_i = dat;  bus.wbs_sel_i = sel;
    if (pulse_done) core_done = 1'b1;
    lat = 99; rdat = 32'hX;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      core_done = 1'b0;
      if (bus.wbs_ack_o === 1'b1) begin
        lat = n; rdat = bus.wbs_dat_o;
        break;
      end
    end
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    @(posedge clk); #1;
    dbl = bus.wbs_ack_o; dat_after = bus.wbs_dat_o;
  endtask

  task automatic pulse_core_done(input logic [127:0] val);
    @(negedge clk);
    core_res = val; core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.wbs_ack_o !== 1'b0) $display("FAIL rst_ack got %b want 0", bus.wbs_ack_o); else passed++;
    total++; if (bus.wbs_dat_o !== 32'h0) $display("FAIL rst_dat got %h want 0", bus.wbs_dat_o); else passed++;
    total++; if (core_start !== 1'b0) $display("FAIL rst_start got %b want 0", core_start); else passed++;
    total++; if (irq !== 1'b0) $display("FAIL rst_irq got %b want 0", irq); else passed++;
    total++; if (core_key !== 256'h0) $display("FAIL rst_key got %h want 0", core_key); else passed++;
    @(negedge clk); rst = 1'b0;
    wb_xfer(1'b0, A_STATUS, 32'h0, 4'hF, 1'b0);
    total++; if (lat !== 1) $display("FAIL rst_status_lat got %0d want 1", lat); else passed++;
    total++; if (rdat !== 32'h0) $display("FAIL rst_status got %h want 0", rdat); else passed++;
  endtask

  task automatic test_byte_sel();
    wb_xfer(1'b1, A_KEY0, 32'hDEADBEEF, 4'b0011, 1'b0);
    total++; if (lat !== 1) $display("FAIL sel_wr_lat got %0d want 1", lat); else passed++;
    total++; if (dbl !== 1'b0) $display("FAIL sel_wr_dbl got %b want 0", dbl); else passed++;
    wb_xfer(1'b0, A_KEY0, 32'h0, 4'hF, 1'b0);
    total++; if (lat !== 1) $display("FAIL sel_rd_lat got %0d want 1", lat); else passed++;
    total++; if (dbl !== 1'b0) $display("FAIL sel_rd_dbl got %b want 0", dbl); else passed++;
    total++; if (rdat !== 32'h0000BEEF) $display("FAIL sel_key0 got %h want 0000beef", rdat); else passed++;
    total++; if (dat_after !== 32'h0) $display("FAIL sel_dat_idle got %h want 0", dat_after); else passed++;
    wb_xfer(1'b1, A_KEY0, 32'hFFFFFFFF, 4'b0000, 1'b0);
    total++; if (lat !== 1) $display("FAIL sel0_lat got %0d want 1", lat); else passed++;
    wb_xfer(1'b0, A_KEY0, 32'h0, 4'hF, 1'b0);
    total++; if (rdat !== 32'h0000BEEF) $display("FAIL sel0_key0 got %h want 0000beef", rdat); else passed++;
    wb_xfer(1'b1, A_KEY0, 32'hA5123456, 4'b1000, 1'b0);
    wb_xfer(1'b0, A_KEY0, 32'h0, 4'hF, 1'b0);
    total++; if (rdat !== 32'hA500BEEF) $display("FAIL sel3_key0 got %h want a500beef", rdat); else passed++;
    total++; if (core_key[31:0] !== 32'hA500BEEF) $display("FAIL sel3_key_o got %h want a500beef", core_key[31:0]); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] pat;
    pat = 4'b0;
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
    bus.wbs_adr_i = A_STATUS; bus.wbs_sel_i = 4'hF;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      pat = {pat[2:0], bus.wbs_ack_o};
    end
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    @(posedge clk); #1;
    total++; if (pat !== 4'b1010) $display("FAIL b2b_ack_pattern got %b want 1010", pat); else passed++;
    total++; if (bus.wbs_ack_o !== 1'b0) $display("FAIL b2b_ack_tail got %b want 0", bus.wbs_ack_o); else passed++;
  endtask

  task automatic test_operation();
    int s0;
    for (int i = 0; i < 8; i++) begin
      exp_key[32*i +: 32] = 32'h1000_0000 + 32'(i) * 32'h0001_1111;
      wb_xfer(1'b1, A_KEY0 + 32'(4*i), exp_key[32*i +: 32], 4'hF, 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      exp_blk[32*i +: 32] = 32'hB000_0000 | 32'(i);
      wb_xfer(1'b1, A_BLK0 + 32'(4*i), exp_blk[32*i +: 32], 4'hF, 1'b0);
    end
    s0 = start_cnt;
    wb_xfer(1'b1, A_CTRL, 32'h3, 4'hF, 1'b0);
    total++; if (start_cnt - s0 !== 1) $display("FAIL op_start_pulses got %0d want 1", start_cnt - s0); else passed++;
    wb_xfer(1'b0, A_STATUS, 32'h0, 4'hF, 1'b0);
    total++; if (rdat !== 32'h1) $display("FAIL op_status_busy got %h want 1", rdat); else passed++;
    wb_xfer(1'b0, A_CTRL, 32'h0, 4'hF, 1'b0);
    total++; if (rdat !== 32'h2) $display("FAIL op_ctrl_rd got %h want 2", rdat); else passed++;
    total++; if (core_key !== exp_key) $display("FAIL op_key_o got %h want %h", core_key, exp_key); else passed++;
    total++; if (core_blk !== exp_blk) $display("FAIL op_blk_o got %h want %h", core_blk, exp_blk); else passed++;
    total++; if (irq !== 1'b0) $display("FAIL op_irq_early got %b want 0", irq); else passed++;
    pulse_core_done(RES_VAL);
    for (int i = 0; i < 4; i++) begin
      wb_xfer(1'b0, A_RES0 + 32'(4*i), 32'h0, 4'hF, 1'b0);
      total++; if (rdat !== RES_VAL[32*i +: 32]) $display("FAIL op_res%0d got %h want %h", i, rdat, RES_VAL[32*i +: 32]); else passed++;
    end
    wb_xfer(1'b0, A_STATUS, 32'h0, 4'hF, 1'b0);
    total++; if (rdat !== 32'h2) $display("FAIL op_status_done got %h want 2", rdat); else passed++;
    total++; if (irq !== 1'b1) $display("FAIL op_irq got %b want 1", irq); else passed++;
    pulse_core_done(128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000);
    wb_xfer(1'b0, A_RES0, 32'h0, 4'hF, 1'b0);
    total++; if (rdat !== 32'h7654CDEF) $display("FAIL op_res_hold got %h want 7654cdef", rdat); else passed++;
  endtask

  task automatic test_busy();
    int s0;
    s0 = start_cnt;
    wb_xfer(1'b1, A_CTRL, 32'h1, 4'hF, 1'b0);
    wb_xfer(1'b1, A_BLK0 + 32'h4, 32'h55, 4'hF, 1'b0);
    total++; if (lat !== 1) $display("FAIL busy_wr_lat got %0d want 1", lat); else passed++;
    wb_xfer(1'b1, A_KEY0, 32'h0BAD_0BAD, 4'hF, 1'b0);
    wb_xfer(1'b1, A_CTRL, 32'h1, 4'hF, 1'b0);
    wb_xfer(1'b0, A_BLK0 + 32'h4, 32'h0, 4'hF, 1'b0);
    total++; if (rdat !== 32'hB000_0001) $display("FAIL busy_blk1 got %h want b0000001", rdat); else passed++;
    wb_xfer(1'b0, A_KEY0, 32'h0, 4'hF, 1'b0);
    total++; if (rdat !== 32'h1000_0000) $display("FAIL busy_key0 got %h want 10000000", rdat); else passed++;
    total++; if (core_blk[63:32] !== 32'hB000_0001) $display("FAIL busy_blk_o got %h want b0000001", core_blk[63:32]); else passed++;
    total++; if (start_cnt - s0 !== 1) $display("FAIL busy_start_pulses got %0d want 1", start_cnt - s0); else passed++;
    wb_xfer(1'b0, A_STATUS, 32'h0, 4'hF, 1'b0);
    total++; if (rdat !== 32'h7) $display("FAIL busy_status got %h want 7", rdat); else passed++;
    total++; if (irq !== 1'b0) $display("FAIL busy_irq_dis got %b want 0", irq); else passed++;
    pulse_core_done(RES_VAL);
    wb_xfer(1'b0, A_STATUS, 32'h0, 4'hF, 1'b0);
    total++; if (rdat !== 32'h6) $display("FAIL busy_status_idle got %h want 6", rdat); else passed++;
    wb_xfer(1'b1, A_CTRL, 32'h4, 4'hF, 1'b0);
    wb_xfer(1'b0, A_STATUS, 32'h0, 4'hF, 1'b0);
    total++; if (rdat !== 32'h0) $display("FAIL busy_clr got %h want 0", rdat); else passed++;
  endtask

  task automatic test_clr_race();
    wb_xfer(1'b1, A_CTRL, 32'h1, 4'hF, 1'b0);
    wb_xfer(1'b1, A_BLK0, 32'h1, 4'hF, 1'b0);
    wb_xfer(1'b1, A_CTRL, 32'h4, 4'hF, 1'b1);
    wb_xfer(1'b0, A_STATUS, 32'h0, 4'hF, 1'b0);
    total++; if (rdat !== 32'h2) $display("FAIL race_status got %h want 2", rdat); else passed++;
  endtask

  task automatic test_unmapped();
    wb_xfer(1'b0, BASE + 32'h10, 32'h0, 4'hF, 1'b0);
    total++; if (lat !== 1) $display("FAIL unm_rd_lat got %0d want 1", lat); else passed++;
    total++; if (rdat !== 32'h0) $display("FAIL unm_rd got %h want 0", rdat); else passed++;
    wb_xfer(1'b1, BASE + 32'h80, 32'hFFFF_FFFF, 4'hF, 1'b0);
    total++; if (lat !== 1) $display("FAIL unm_wr_lat got %0d want 1", lat); else passed++;
    wb_xfer(1'b1, A_STATUS, 32'hFFFF_FFFF, 4'hF, 1'b0);
    wb_xfer(1'b0, BASE + 32'h80, 32'h0, 4'hF, 1'b0);
    total++; if (rdat !== 32'h0) $display("FAIL unm_rd80 got %h want 0", rdat); else passed++;
    wb_xfer(1'b0, A_STATUS, 32'h0, 4'hF, 1'b0);
    total++; if (rdat !== 32'h2) $display("FAIL unm_status got %h want 2", rdat); else passed++;
    wb_xfer(1'b0, A_CTRL, 32'h0, 4'hF, 1'b0);
    total++; if (rdat !== 32'h0) $display("FAIL unm_ctrl got %h want 0", rdat); else passed++;
    wb_xfer(1'b0, A_KEY0, 32'h0, 4'hF, 1'b0);
    total++; if (rdat !== 32'h1000_0000) $display("FAIL unm_key0 got %h want 10000000", rdat); else passed++;
    wb_xfer(1'b0, A_BLK0, 32'h0, 4'hF, 1'b0);
    total++; if (rdat !== 32'hB000_0000) $display("FAIL unm_blk0 got %h want b0000000", rdat); else passed++;
  endtask

  task automatic test_reset_abort();
    logic seen_ack;
    wb_xfer(1'b1, A_CTRL, 32'h3, 4'hF, 1'b0);
    total++; if (irq !== 1'b1) $display("FAIL abort_irq_pre got %b want 1", irq); else passed++;
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
    bus.wbs_adr_i = A_STATUS; bus.wbs_sel_i = 4'hF;
    rst = 1'b1;
    #1;
    total++; if (irq !== 1'b0) $display("FAIL abort_irq_async got %b want 0", irq); else passed++;
    seen_ack = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.wbs_ack_o !== 1'b0) seen_ack = 1'b1;
    end
    total++; if (seen_ack !== 1'b0) $display("FAIL abort_ack got %b want 0", seen_ack); else passed++;
    @(negedge clk);
    rst = 1'b0; bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    wb_xfer(1'b0, A_STATUS, 32'h0, 4'hF, 1'b0);
    total++; if (lat !== 1) $display("FAIL abort_new_lat got %0d want 1", lat); else passed++;
    total++; if (rdat !== 32'h0) $display("FAIL abort_status got %h want 0", rdat); else passed++;
    wb_xfer(1'b0, A_KEY0, 32'h0, 4'hF, 1'b0);
    total++; if (rdat !== 32'h0) $display("FAIL abort_key0 got %h want 0", rdat); else passed++;
    total++; if (irq !== 1'b0) $display("FAIL abort_irq got %b want 0", irq); else passed++;
    pulse_core_done(RES_VAL);
    wb_xfer(1'b0, A_RES0, 32'h0, 4'hF, 1'b0);
    total++; if (rdat !== 32'h0) $display("FAIL abort_res0 got %h want 0", rdat); else passed++;
  endtask

  initial begin
    rst = 1'b1;
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = 4'h0; bus.wbs_adr_i = 32'h0; bus.wbs_dat_i = 32'h0;
    core_busy = 1'b0; core_done = 1'b0; core_res = '0;
    test_reset();
    test_byte_sel();
    test_back_to_back();
    test_operation();
    test_busy();
    test_clr_race();
    test_unmapped();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
